minus_n_counter: RTL and testbench
==================================

// Module: minus_n_counter
// PURPOSE
//   Loadable, parametrised down-counter: generalises the 4-bit minus-one/over FSM.
//   Counts a loaded value down by a runtime step, one decrement per enabled cycle.
//   Flags underflow through Cout, with a selectable wrap or saturate mode.
//   Pulses done at terminal count. Sits between a host that loads values and
//   downstream logic that consumes Res.
// PARAMETERS
//   WIDTH   4      counter / load_value / Res width in bits
//   STEP_W  WIDTH  width of step input; must be <= WIDTH; zero-extended to WIDTH internally
// PORTS
//   clock       in   1        sole clock; all state updates on posedge
//   reset       in   1        synchronous, active-high; sampled on posedge clock only
//   load_valid  in   1        host offers load_value
//   load_ready  out  1        block accepts a load (comb: state != RUN)
//   load_value  in   WIDTH    start value
//   step        in   STEP_W   decrement amount, sampled every RUN cycle
//   enable      in   1        decrement permitted this cycle (RUN only)
//   sat_mode    in   1        1 = saturate at 0 on underflow; 0 = wrap modulo 2^WIDTH
//   Res         out  WIDTH    current count (registered)
//   Cout        out  1        underflow flag (registered)
//   done        out  1        one-cycle pulse on terminal count (registered)
//   busy        out  1        comb: state == RUN
// BEHAVIOUR
//   - States: IDLE=2'd0, RUN=2'd1, OVER=2'd2. Encoding 2'd3 is illegal and returns to IDLE next edge.
//   - Reset (sync): state=IDLE, Res=0, Cout=0, done=0. Reset wins over every other event.
//     A mid-count reset aborts the count at that edge.
//   - done defaults to 0 each cycle; it is set only in the cases listed below.
//   - IDLE/OVER: a load fires when load_valid && load_ready (handshake completes at that edge).
//     On a load: Res<=load_value and Cout<=0.
//       - load_value != 0: state<=RUN.
//       - load_value == 0: state<=OVER, Cout<=1, done<=1.
//     With no load, Res and Cout hold. enable is ignored.
//   - RUN: load_valid is ignored (load_ready=0). The state holds unless enable=1 and step!=0.
//     Decrement latency is 1 cycle. Let s = zero-extended step:
//       - Res > s:  Res<=Res-s, stay RUN.
//       - Res == s: Res<=0, done<=1, Cout stays 0, state<=OVER.
//       - Res < s:  Cout<=1, done<=1, state<=OVER;
//                   Res<=0 if sat_mode, else Res<=(Res-s) mod 2^WIDTH.
//   - step==0 with enable=1: no change and no event (no stall detection).
//   - Cout is sticky in OVER until the next accepted load or reset.
//   - sat_mode and step are sampled at the decrementing edge; mid-count changes are legal.
// CONFIGURATION
//   MINUS_N_AUTO_RELOAD_EN defined:
//     - An internal reload_q register captures load_value on every accepted nonzero load.
//     - At terminal count or underflow in RUN: Res<=reload_q, state stays RUN, done<=1.
//     - Cout is a one-cycle pulse on underflow instead of sticky. Zero loads still go to OVER.
//     - load_ready stays 0 while RUN. Only reset exits auto-reload running.
//   Undefined: behaviour exactly as above; no reload_q register exists.
// STRUCTURE
//   - Package minus_pkg: state localparams IDLE/RUN/OVER, state_t typedef (2 bits).
//   - Sub-module minus_sat_sub (combinational):
//       inputs a[WIDTH], b[WIDTH], sat;
//       outputs diff[WIDTH], borrow, zero (diff==0 && !borrow).
//   - Top holds the FSM, registers, handshake and optional reload_q.
// TESTING
//   1. reset=1 for 2 cycles mid-RUN (Res=9) -> next edge Res=0, Cout=0, done=0, busy=0, load_ready=1.
//   2. WIDTH=4: load 5, step=1, enable=1 -> Res 4,3,2,1,0 on successive edges;
//      done=1 on the 0 edge only, Cout=0, state OVER.
//   3. load 3, step=5, sat_mode=0 -> Res=14, Cout=1, done pulse;
//      repeat with sat_mode=1 -> Res=0, Cout=1.
//   4. load 0 -> Cout=1 and done=1 after one edge, busy=0;
//      load_valid while RUN (load 7, enable=0) -> ignored, Res stays 7.
//   5. load 6, step=2, toggle enable 1,0,1,1 -> Res 4,4,2,0; step=0 with enable=1 holds Res.
//   6. MINUS_N_AUTO_RELOAD_EN: load 2, step=1 -> Res 1,0->2 reload;
//      done pulses at each wrap, busy stays 1; step=3 from Res=2 -> Cout pulses 1 cycle.

Source files
------------

// File: rtl/minus_pkg.sv
// Shared state type for the minus-N down-counter.
package minus_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;
endpackage

// File: rtl/minus_sat_sub.sv
// Combinational a-b with borrow detect and optional clamp-to-zero on underflow.
module minus_sat_sub #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sat,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero
);
  always_comb begin
    borrow = (a < b);
    diff   = (borrow && sat) ? '0 : (a - b);
    zero   = (diff == '0) && !borrow;
  end
endmodule

// File: rtl/minus_n_counter.sv
// Loadable down-counter decrementing by a runtime step, with underflow/done flags.
// Optional auto-reload on terminal count: define MINUS_N_AUTO_RELOAD_EN.
module minus_n_counter
  import minus_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int STEP_W = WIDTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [WIDTH-1:0]  load_value,
  input  logic [STEP_W-1:0] step,
  input  logic              enable,
  input  logic              sat_mode,
  output logic [WIDTH-1:0]  Res,
  output logic              Cout,
  output logic              done,
  output logic              busy
);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;
`ifdef MINUS_N_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  logic [WIDTH-1:0] step_ext;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             zero;

  assign step_ext = WIDTH'(step);

  minus_sat_sub #(.WIDTH(WIDTH)) u_sub (
    .a      (res_q),
    .b      (step_ext),
    .sat    (sat_mode),
    .diff   (diff),
    .borrow (borrow),
    .zero   (zero)
  );

  assign busy       = (state_q == RUN);
  assign load_ready = (state_q != RUN);
  assign Res        = res_q;
  assign Cout       = cout_q;
  assign done       = done_q;

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
`ifdef MINUS_N_AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    case (state_q)
      IDLE, OVER: begin
        if (load_valid) begin
          res_d  = load_value;
          cout_d = 1'b0;
          if (load_value != '0) begin
            state_d = RUN;
`ifdef MINUS_N_AUTO_RELOAD_EN
            reload_d = load_value;
`endif
          end else begin
            state_d = OVER;
            cout_d  = 1'b1;
            done_d  = 1'b1;
          end
        end
      end
      RUN: begin
`ifdef MINUS_N_AUTO_RELOAD_EN
        // Cout is a single-cycle underflow pulse while auto-reloading.
        cout_d = 1'b0;
`endif
        if (enable && (step_ext != '0)) begin
          if (zero || borrow) begin
            done_d = 1'b1;
            cout_d = borrow;
`ifdef MINUS_N_AUTO_RELOAD_EN
            res_d  = reload_q;
`else
            res_d   = diff;
            state_d = OVER;
`endif
          end else begin
            res_d = diff;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      res_q   <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MINUS_N_AUTO_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
`ifdef MINUS_N_AUTO_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end
endmodule

// File: tb/tb_minus_n_counter.sv
// Self-checking bench for minus_n_counter (WIDTH=4) against an arithmetic reference model.
module tb_minus_n_counter;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       load_valid = 1'b0;
  logic       load_ready;
  logic [3:0] load_value = '0;
  logic [3:0] step = '0;
  logic       enable = 1'b0;
  logic       sat_mode = 1'b0;
  logic [3:0] Res;
  logic       Cout;
  logic       done;
  logic       busy;

  int checks = 0;
  int failures = 0;

  logic [3:0] m_res = '0;
  logic [3:0] m_reload = '0;
  logic       m_cout = 1'b0;
  logic       m_done = 1'b0;
  logic       m_run = 1'b0;

  minus_n_counter #(.WIDTH(4), .STEP_W(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_value (load_value),
    .step       (step),
    .enable     (enable),
    .sat_mode   (sat_mode),
    .Res        (Res),
    .Cout       (Cout),
    .done       (done),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] dut_vec();
    return {Res, Cout, done, busy, load_ready};
  endfunction

  function automatic logic [7:0] mdl_vec();
    return {m_res, m_cout, m_done, m_run, !m_run};
  endfunction

  // Advance the reference model by one edge using the inputs presented now.
  task automatic model_step();
    int d;
    m_done = 1'b0;
    if (reset) begin
      m_run = 1'b0; m_res = '0; m_cout = 1'b0;
    end else if (!m_run) begin
      if (load_valid) begin
        m_res  = load_value;
        m_cout = 1'b0;
        if (load_value != 0) begin
          m_run = 1'b1; m_reload = load_value;
        end else begin
          m_cout = 1'b1; m_done = 1'b1;
        end
      end
    end else begin
`ifdef MINUS_N_AUTO_RELOAD_EN
      m_cout = 1'b0;
`endif
      if (enable && step != 0) begin
        d = int'(m_res) - int'(step);
        if (d > 0) m_res = d[3:0];
        else begin
          m_done = 1'b1;
          if (d < 0) m_cout = 1'b1;
`ifdef MINUS_N_AUTO_RELOAD_EN
          m_res = m_reload;
`else
          m_run = 1'b0;
          m_res = (d == 0 || sat_mode) ? 4'd0 : 4'(d + 16);
`endif
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    load_valid = 0; enable = 0; reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic load(input logic [3:0] v);
    load_valid = 1; load_value = v;
    tick();
    load_valid = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    tick(); tick();
    checks++;
    if (dut_vec() !== 8'b0000_0001) begin
      failures++; $display("FAIL reset_initial: got %b expected %b", dut_vec(), 8'b0000_0001);
    end
    reset = 0;
    load(4'd9);
    checks++;
    if (Res !== 4'd9 || busy !== 1'b1) begin
      failures++; $display("FAIL reset_load9: got Res=%0d busy=%b expected Res=9 busy=1", Res, busy);
    end
    reset = 1;
    tick(); tick();
    reset = 0;
    checks++;
    if (dut_vec() !== 8'b0000_0001 || dut_vec() !== mdl_vec()) begin
      failures++; $display("FAIL reset_midrun: got %b expected %b", dut_vec(), 8'b0000_0001);
    end
  endtask

  task automatic test_count_down();
    logic [3:0] exp_res [5] = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    do_reset();
    step = 1; sat_mode = 0;
    load(4'd5);
    enable = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        failures++; $display("FAIL count_down_model[%0d]: got %b expected %b", i, dut_vec(), mdl_vec());
      end
`ifndef MINUS_N_AUTO_RELOAD_EN
      checks++;
      if (Res !== exp_res[i] || done !== (i == 4) || Cout !== 1'b0) begin
        failures++; $display("FAIL count_down[%0d]: got Res=%0d done=%b Cout=%b expected Res=%0d done=%b Cout=0",
                             i, Res, done, Cout, exp_res[i], (i == 4));
      end
`endif
    end
    enable = 0;
  endtask

  task automatic test_underflow();
    for (int m = 0; m < 2; m++) begin
      do_reset();
      sat_mode = (m == 1);
      load(4'd3);
      step = 5; enable = 1;
      tick();
      enable = 0;
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        failures++; $display("FAIL underflow_model sat=%0d: got %b expected %b", m, dut_vec(), mdl_vec());
      end
`ifndef MINUS_N_AUTO_RELOAD_EN
      checks++;
      if (Res !== ((m == 1) ? 4'd0 : 4'd14) || Cout !== 1'b1 || done !== 1'b1) begin
        failures++; $display("FAIL underflow sat=%0d: got Res=%0d Cout=%b done=%b expected Res=%0d Cout=1 done=1",
                             m, Res, Cout, done, (m == 1) ? 0 : 14);
      end
      tick();
      checks++;
      if (Cout !== 1'b1 || done !== 1'b0) begin
        failures++; $display("FAIL underflow_sticky sat=%0d: got Cout=%b done=%b expected Cout=1 done=0", m, Cout, done);
      end
`endif
    end
  endtask

  task automatic test_zero_load_and_ignore();
    do_reset();
    load(4'd0);
    checks++;
    if (Cout !== 1'b1 || done !== 1'b1 || busy !== 1'b0 || Res !== 4'd0) begin
      failures++; $display("FAIL zero_load: got Cout=%b done=%b busy=%b Res=%0d expected 1 1 0 0", Cout, done, busy, Res);
    end
    tick();
    checks++;
    if (dut_vec() !== mdl_vec() || done !== 1'b0) begin
      failures++; $display("FAIL zero_load_after: got %b expected %b", dut_vec(), mdl_vec());
    end
    enable = 0;
    load(4'd7);
    load_valid = 1; load_value = 4'd2;
    tick(); tick();
    load_valid = 0;
    checks++;
    if (Res !== 4'd7 || load_ready !== 1'b0 || dut_vec() !== mdl_vec()) begin
      failures++; $display("FAIL load_ignored_in_run: got Res=%0d load_ready=%b expected Res=7 load_ready=0", Res, load_ready);
    end
  endtask

  task automatic test_enable_toggle();
    logic       en_seq  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [3:0] exp_res [4] = '{4'd4, 4'd4, 4'd2, 4'd0};
    do_reset();
    step = 2; sat_mode = 0;
    load(4'd6);
    for (int i = 0; i < 4; i++) begin
      enable = en_seq[i];
      tick();
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        failures++; $display("FAIL enable_toggle_model[%0d]: got %b expected %b", i, dut_vec(), mdl_vec());
      end
`ifndef MINUS_N_AUTO_RELOAD_EN
      checks++;
      if (Res !== exp_res[i]) begin
        failures++; $display("FAIL enable_toggle[%0d]: got Res=%0d expected Res=%0d", i, Res, exp_res[i]);
      end
`endif
    end
    do_reset();
    load(4'd5);
    step = 0; enable = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (Res !== 4'd5 || done !== 1'b0 || busy !== 1'b1) begin
        failures++; $display("FAIL step_zero[%0d]: got Res=%0d done=%b busy=%b expected Res=5 done=0 busy=1", i, Res, done, busy);
      end
    end
    enable = 0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      reset      = ($urandom_range(0, 39) == 0);
      load_valid = $urandom_range(0, 3) == 0;
      load_value = 4'($urandom_range(0, 15));
      step       = 4'($urandom_range(0, 15) < 10 ? $urandom_range(0, 3) : $urandom_range(0, 15));
      enable     = $urandom_range(0, 3) != 0;
      sat_mode   = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        failures++; $display("FAIL random[%0d]: got %b expected %b", i, dut_vec(), mdl_vec());
      end
    end
    reset = 0; load_valid = 0; enable = 0;
  endtask

`ifdef MINUS_N_AUTO_RELOAD_EN
  task automatic test_auto_reload();
    logic [3:0] exp_res [4] = '{4'd1, 4'd2, 4'd1, 4'd2};
    do_reset();
    step = 1; sat_mode = 0;
    load(4'd2);
    enable = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (Res !== exp_res[i] || done !== (i % 2 == 1) || busy !== 1'b1) begin
        failures++; $display("FAIL auto_reload[%0d]: got Res=%0d done=%b busy=%b expected Res=%0d done=%b busy=1",
                             i, Res, done, busy, exp_res[i], (i % 2 == 1));
      end
    end
    step = 3;
    tick();
    enable = 0;
    checks++;
    if (Res !== 4'd2 || Cout !== 1'b1 || done !== 1'b1) begin
      failures++; $display("FAIL auto_underflow: got Res=%0d Cout=%b done=%b expected 2 1 1", Res, Cout, done);
    end
    tick();
    checks++;
    if (Cout !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL auto_cout_pulse: got Cout=%b busy=%b expected 0 1", Cout, busy);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_count_down();
    test_underflow();
    test_zero_load_and_ignore();
    test_enable_toggle();
`ifdef MINUS_N_AUTO_RELOAD_EN
    test_auto_reload();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
